// File: rtl/calc_dev_mc.sv
// Command-driven calculator: one command word, up to two operands, ALU result
// into one of NREG registers, optional push of the result into an output FIFO.
module calc_dev_mc #(
  parameter int unsigned DW        = 8,
  parameter int unsigned NREG      = 4,
  parameter int unsigned OUT_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cs,
  input  logic [DW-1:0] din,
  input  logic          rd,
  output logic          busy,
  output logic [DW-1:0] dout,
  output logic          drdy,
  output logic          flag
);

  localparam int unsigned RW = (NREG > 1) ? $clog2(NREG) : 1;
  localparam int unsigned PW = $clog2(OUT_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [2:0] {IDLE, OP1, OP2, EXEC, TX} state_t;

  state_t state, state_nxt;

  // Command bit 0 only steers the FSM at accept time, so it is not kept.
  logic [7:1]    cmd_q;
  logic [DW-1:0] op1_q, op2_q, res_q;
  logic [DW-1:0] regs_q [NREG];
  logic          flag_q;

  logic [DW-1:0] fifo_q [OUT_DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;

  logic          latch_c, ld_op1_c, ld_op2_c, exec_c, push_c, pop_c, full_c;
  logic [RW-1:0] sel_c;
  logic [DW-1:0] a_c, b_c, alu_res_c;
  logic [DW:0]   sum_c, diff_c;
  logic          alu_flag_c;

  assign full_c = (count_q == CW'(OUT_DEPTH));
  assign pop_c  = rd && (count_q != '0);
  assign sel_c  = RW'({30'd0, cmd_q[7:6]} % NREG);

  // ALU: acc mode folds the selected register in as the left operand.
  always_comb begin
    a_c        = cmd_q[4] ? regs_q[sel_c] : op1_q;
    b_c        = cmd_q[4] ? op1_q : op2_q;
    sum_c      = {1'b0, a_c} + {1'b0, b_c};
    diff_c     = {1'b0, a_c} - {1'b0, b_c};
    alu_res_c  = '0;
    alu_flag_c = 1'b0;
    case (cmd_q[3:2])
      2'b00: begin
        alu_res_c  = sum_c[DW-1:0];
        alu_flag_c = sum_c[DW];
      end
      2'b01: begin
        alu_res_c  = diff_c[DW-1:0];
        alu_flag_c = diff_c[DW];
      end
      2'b10:   alu_res_c = a_c & b_c;
      default: alu_res_c = a_c ^ b_c;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    latch_c   = 1'b0;
    ld_op1_c  = 1'b0;
    ld_op2_c  = 1'b0;
    exec_c    = 1'b0;
    push_c    = 1'b0;
    case (state)
      IDLE: begin
        if (cs) begin
          latch_c = 1'b1;
          if (din[0])      state_nxt = OP1;
          else if (din[1]) state_nxt = OP2;
          else             state_nxt = EXEC;
        end
      end
      OP1: begin
        ld_op1_c  = 1'b1;
        state_nxt = cmd_q[1] ? OP2 : EXEC;
      end
      OP2: begin
        ld_op2_c  = 1'b1;
        state_nxt = EXEC;
      end
      EXEC: begin
        exec_c    = 1'b1;
        state_nxt = cmd_q[5] ? TX : IDLE;
      end
      TX: begin
        // A same-cycle pop frees a slot even when the FIFO is full.
        if (!full_c || rd) begin
          push_c    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q   <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      res_q   <= '0;
      flag_q  <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(NREG); i++) regs_q[i] <= '0;
    end else begin
      // Operands are cleared at accept so an absent operand reads as zero.
      if (latch_c) begin
        cmd_q <= din[7:1];
        op1_q <= '0;
        op2_q <= '0;
      end
      if (ld_op1_c) op1_q <= din;
      if (ld_op2_c) op2_q <= din;
      if (exec_c) begin
        regs_q[sel_c] <= alu_res_c;
        res_q         <= alu_res_c;
        flag_q        <= alu_flag_c;
      end
      if (push_c) wptr_q <= wptr_q + PW'(1);
      if (pop_c)  rptr_q <= rptr_q + PW'(1);
      case ({push_c, pop_c})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_c) fifo_q[wptr_q] <= res_q;
  end

  assign busy = (state != IDLE);
  assign drdy = (count_q != '0);
  assign dout = drdy ? fifo_q[rptr_q] : '0;
  assign flag = flag_q;

endmodule

// File: tb/tb_calc_dev_mc.sv
// Bench for calc_dev_mc: vector table, hand-written corner sequences and
// random commands against a register/queue reference model.
module tb_calc_dev_mc;

  localparam int NREG  = 4;
  localparam int DEPTH = 2;

  logic       clk;
  logic       rst;
  logic       cs;
  logic [7:0] din;
  logic       rd;
  logic       busy;
  logic [7:0] dout;
  logic       drdy;
  logic       flag;

  int checks = 0;
  int errors = 0;

  int         m_r [NREG];
  logic       m_flag;
  logic [7:0] m_fifo [$];

  typedef struct {
    logic [7:0] cmd;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] dout;
    logic       flag;
    int         busy;
  } vec_t;

  vec_t tbl [9];

  calc_dev_mc #(.DW(8), .NREG(NREG), .OUT_DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .cs   (cs),
    .din  (din),
    .rd   (rd),
    .busy (busy),
    .dout (dout),
    .drdy (drdy),
    .flag (flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic void model(input logic [7:0] c, input logic [7:0] a, input logic [7:0] b,
                                output logic [7:0] r, output logic f);
    int o1, o2, x, y, s, sel;
    sel = int'(c[7:6]) % NREG;
    o1  = c[0] ? int'(a) : 0;
    o2  = c[1] ? int'(b) : 0;
    x   = c[4] ? m_r[sel] : o1;
    y   = c[4] ? o1 : o2;
    case (c[3:2])
      2'd0:    begin s = x + y; f = (s > 255); end
      2'd1:    begin s = x - y; f = (x < y);   end
      2'd2:    begin s = x & y; f = 1'b0;      end
      default: begin s = x ^ y; f = 1'b0;      end
    endcase
    r = 8'(s & 255);
  endfunction

  function automatic void model_commit(input logic [7:0] c, input logic [7:0] r, input logic f);
    m_r[int'(c[7:6]) % NREG] = int'(r);
    m_flag = f;
    if (c[5]) m_fifo.push_back(r);
  endfunction

  function automatic logic [7:0] head();
    return (m_fifo.size() != 0) ? m_fifo[0] : 8'h00;
  endfunction

  // Issue one command at a negedge; optional spurious strobe at loop step inj.
  task automatic do_cmd(input logic [7:0] c, input logic [7:0] a, input logic [7:0] b, input int inj);
    logic [7:0] ops [$];
    logic [7:0] r;
    logic       f;
    int         cnt;
    bit         done;
    model(c, a, b, r, f);
    if (c[0]) ops.push_back(a);
    if (c[1]) ops.push_back(b);
    chk("idle_before_cmd", busy, 0);
    cs  = 1'b1;
    din = c;
    cnt = 0;
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      cs = 1'b0;
      if (!busy) begin
        done = 1;
      end else begin
        cnt++;
        if (i == inj) begin
          cs  = 1'b1;
          din = 8'h03;
        end else if (ops.size() != 0) begin
          din = ops.pop_front();
        end else begin
          din = 8'h00;
        end
      end
    end
    cs = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL cmd_timeout cmd=%0h busy still high after 20 cycles", c);
    end
    chk("busy_len", cnt, 32'(int'(c[0]) + int'(c[1]) + 1 + int'(c[5])));
    model_commit(c, r, f);
    chk("flag", flag, m_flag);
    chk("drdy", drdy, m_fifo.size() != 0);
    chk("dout_head", dout, head());
  endtask

  task automatic pop_one();
    chk("pop_head", dout, head());
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    if (m_fifo.size() != 0) void'(m_fifo.pop_front());
    chk("drdy_after_pop", drdy, m_fifo.size() != 0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) m_r[i] = 0;
    m_flag = 1'b0;
    m_fifo.delete();
  endtask

  initial begin
    logic [7:0] c, a, b, r;
    logic       f;

    tbl[0] = '{8'h03, 8'hF0, 8'h20, 8'h00, 1'b1, 3};
    tbl[1] = '{8'h31, 8'h05, 8'h00, 8'h15, 1'b0, 3};
    tbl[2] = '{8'h27, 8'h03, 8'h05, 8'hFE, 1'b1, 4};
    tbl[3] = '{8'h2B, 8'hF0, 8'h3C, 8'h30, 1'b0, 4};
    tbl[4] = '{8'h2F, 8'hF0, 8'h3C, 8'hCC, 1'b0, 4};
    tbl[5] = '{8'h24, 8'h00, 8'h00, 8'h00, 1'b0, 2};
    tbl[6] = '{8'h41, 8'h80, 8'h00, 8'h00, 1'b0, 2};
    tbl[7] = '{8'h72, 8'h00, 8'h55, 8'h80, 1'b0, 3};
    tbl[8] = '{8'h75, 8'h81, 8'h00, 8'hFF, 1'b1, 3};

    rst = 1'b1;
    cs  = 1'b0;
    din = 8'h00;
    rd  = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_drdy", drdy, 0);
    chk("rst_dout", dout, 0);
    chk("rst_flag", flag, 0);

    // Directed vectors with hand-derived results.
    for (int i = 0; i < 9; i++) begin
      do_cmd(tbl[i].cmd, tbl[i].a, tbl[i].b, -1);
      chk("tbl_flag", flag, tbl[i].flag);
      if (tbl[i].cmd[5]) begin
        chk("tbl_dout", dout, tbl[i].dout);
        pop_one();
      end
    end

    // Third transmit stalls on a full FIFO until a pop frees a slot.
    do_cmd(8'h21, 8'h11, 8'h00, -1);
    do_cmd(8'h21, 8'h22, 8'h00, -1);
    chk("stall_idle", busy, 0);
    cs  = 1'b1;
    din = 8'h21;
    @(negedge clk);
    cs  = 1'b0;
    din = 8'h33;
    @(negedge clk);
    din = 8'h00;
    model(8'h21, 8'h33, 8'h00, r, f);
    repeat (3) begin
      @(negedge clk);
      chk("stall_busy", busy, 1);
    end
    chk("stall_head", dout, 8'h11);
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    void'(m_fifo.pop_front());
    model_commit(8'h21, r, f);
    chk("stall_release_busy", busy, 0);
    chk("stall_release_drdy", drdy, 1);
    chk("stall_release_dout", dout, 8'h22);
    pop_one();
    chk("stall_third", dout, 8'h33);
    pop_one();
    chk("stall_empty", drdy, 0);

    // Strobe during busy must not start another command.
    do_cmd(8'h60, 8'h00, 8'h00, 0);
    @(negedge clk);
    chk("ignored_cs_busy", busy, 0);
    chk("ignored_cs_fifo", m_fifo.size() == 1 ? drdy : 1'b0, 1);
    pop_one();
    do_cmd(8'h30, 8'h00, 8'h00, -1);
    chk("ignored_cs_r0", dout, 8'h33);
    pop_one();

    // Reset while in OP2 abandons the command and clears everything.
    do_cmd(8'h21, 8'h44, 8'h00, -1);
    cs  = 1'b1;
    din = 8'h03;
    @(negedge clk);
    cs  = 1'b0;
    din = 8'h10;
    @(negedge clk);
    chk("midop_busy", busy, 1);
    rst = 1'b1;
    din = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk("midop_rst_busy", busy, 0);
    chk("midop_rst_drdy", drdy, 0);
    chk("midop_rst_dout", dout, 0);
    chk("midop_rst_flag", flag, 0);
    do_cmd(8'h31, 8'h07, 8'h00, -1);
    chk("midop_next_dout", dout, 8'h07);
    pop_one();

    // Random commands against the model.
    repeat (200) begin
      c = 8'($urandom);
      a = 8'($urandom);
      b = 8'($urandom);
      if (c[5] && m_fifo.size() == DEPTH) pop_one();
      do_cmd(c, a, b, -1);
      if ($urandom_range(0, 2) == 0 && m_fifo.size() != 0) pop_one();
    end
    while (m_fifo.size() != 0) pop_one();
    chk("final_drdy", drdy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
